svc_axi_resp_delay: RTL and testbench

//   AXI4 response-latency injector between the cache SoC AXI master and the backing memory.

---
 rtl/svc_axi_resp_delay.sv | 225 ++++++++++++++++++++++
 tb/tb_svc_axi_resp_delay.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svc_axi_resp_delay.sv
// AXI4 response-latency injector: AW/W/AR pass straight through, R and B are
// re-timed through one-entry holding registers with a per-beat extra wait.
module svc_axi_resp_delay #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH   = 2,
  parameter int DELAY_WIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DELAY_WIDTH-1:0]        rd_delay,
  input  logic [DELAY_WIDTH-1:0]        wr_delay,
  // upstream AW/W/AR
  input  logic                          s_axi_awvalid,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  output logic                          s_axi_awready,
  input  logic                          s_axi_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,
  output logic                          s_axi_wready,
  input  logic                          s_axi_arvalid,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  output logic                          s_axi_arready,
  // upstream R/B
  output logic                          s_axi_rvalid,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  input  logic                          s_axi_rready,
  output logic                          s_axi_bvalid,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_bready,
  // memory AW/W/AR
  output logic                          m_axi_awvalid,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  input  logic                          m_axi_awready,
  output logic                          m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_wready,
  output logic                          m_axi_arvalid,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  input  logic                          m_axi_arready,
  // memory R/B
  input  logic                          m_axi_rvalid,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  output logic                          m_axi_rready,
  input  logic                          m_axi_bvalid,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_bready,
  output logic                          rd_busy,
  output logic                          wr_busy
);

  localparam int RPW = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3;
  localparam int BPW = AXI_ID_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  assign m_axi_awvalid = s_axi_awvalid;
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign s_axi_awready = m_axi_awready;
  assign m_axi_wvalid  = s_axi_wvalid;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign s_axi_wready  = m_axi_wready;
  assign m_axi_arvalid = s_axi_arvalid;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign s_axi_arready = m_axi_arready;

  // Handshake rule for both engines: a beat moves on a side only in a cycle
  // where that side's valid and ready are both high; valid never waits on ready.

  // ---------------- R engine ----------------
  state_t                 r_rd_st;
  logic [DELAY_WIDTH-1:0] r_rd_cnt;
  logic [RPW-1:0]         r_rd_payload;
  logic                   w_rd_accept;

  assign m_axi_rready = (r_rd_st == ST_EMPTY) || ((r_rd_st == ST_PRESENT) && s_axi_rready);
  assign w_rd_accept  = m_axi_rvalid && m_axi_rready;
  assign s_axi_rvalid = (r_rd_st == ST_PRESENT);
  assign rd_busy      = (r_rd_st != ST_EMPTY);
  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_rd_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_st  <= ST_EMPTY;
      r_rd_cnt <= '0;
    end else begin
      case (r_rd_st)
        ST_EMPTY: begin
          if (w_rd_accept) begin
            r_rd_cnt <= rd_delay;
            r_rd_st  <= (rd_delay == '0) ? ST_PRESENT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_rd_cnt <= r_rd_cnt - 1'b1;
          if (r_rd_cnt == DELAY_WIDTH'(1)) r_rd_st <= ST_PRESENT;
        end
        ST_PRESENT: begin
          // An accept here implies the upstream handshake in the same cycle.
          if (w_rd_accept) begin
            r_rd_cnt <= rd_delay;
            r_rd_st  <= (rd_delay == '0) ? ST_PRESENT : ST_WAIT;
          end else if (s_axi_rready) begin
            r_rd_st  <= ST_EMPTY;
          end
        end
        default: begin
          r_rd_st  <= ST_EMPTY;
          r_rd_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_accept) r_rd_payload <= {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
  end

  // ---------------- B engine ----------------
  state_t                 r_wr_st;
  logic [DELAY_WIDTH-1:0] r_wr_cnt;
  logic [BPW-1:0]         r_wr_payload;
  logic                   w_wr_accept;

  assign m_axi_bready = (r_wr_st == ST_EMPTY) || ((r_wr_st == ST_PRESENT) && s_axi_bready);
  assign w_wr_accept  = m_axi_bvalid && m_axi_bready;
  assign s_axi_bvalid = (r_wr_st == ST_PRESENT);
  assign wr_busy      = (r_wr_st != ST_EMPTY);
  assign {s_axi_bid, s_axi_bresp} = r_wr_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_st  <= ST_EMPTY;
      r_wr_cnt <= '0;
    end else begin
      case (r_wr_st)
        ST_EMPTY: begin
          if (w_wr_accept) begin
            r_wr_cnt <= wr_delay;
            r_wr_st  <= (wr_delay == '0) ? ST_PRESENT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wr_cnt <= r_wr_cnt - 1'b1;
          if (r_wr_cnt == DELAY_WIDTH'(1)) r_wr_st <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (w_wr_accept) begin
            r_wr_cnt <= wr_delay;
            r_wr_st  <= (wr_delay == '0) ? ST_PRESENT : ST_WAIT;
          end else if (s_axi_bready) begin
            r_wr_st  <= ST_EMPTY;
          end
        end
        default: begin
          r_wr_st  <= ST_EMPTY;
          r_wr_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) r_wr_payload <= {m_axi_bid, m_axi_bresp};
  end

`ifdef FORMAL
  localparam int MAXW = (1 << DELAY_WIDTH) - 1;

  a_r_stable: assert property (@(posedge clk) disable iff (rst)
    s_axi_rvalid && !s_axi_rready |=> s_axi_rvalid && $stable(r_rd_payload));
  a_b_stable: assert property (@(posedge clk) disable iff (rst)
    s_axi_bvalid && !s_axi_bready |=> s_axi_bvalid && $stable(r_wr_payload));
  a_r_cnt: assert property (@(posedge clk) disable iff (rst)
    r_rd_st != ST_WAIT |-> r_rd_cnt == '0);
  a_b_cnt: assert property (@(posedge clk) disable iff (rst)
    r_wr_st != ST_WAIT |-> r_wr_cnt == '0);
  a_r_wait: assert property (@(posedge clk) disable iff (rst)
    r_rd_st == ST_WAIT |-> ##[1:MAXW] r_rd_st != ST_WAIT);
  a_b_wait: assert property (@(posedge clk) disable iff (rst)
    r_wr_st == ST_WAIT |-> ##[1:MAXW] r_wr_st != ST_WAIT);
`endif

endmodule

// File: tb/tb_svc_axi_resp_delay.sv
// Directed bench for svc_axi_resp_delay: pass-through, R/B delay timing,
// back-pressure, back-to-back streaming and asynchronous reset.
module tb_svc_axi_resp_delay;

  localparam int AW  = 12;
  localparam int DW  = 128;
  localparam int IW  = 2;
  localparam int DLW = 2;

  logic clk, rst;
  logic [DLW-1:0] rd_delay, wr_delay;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_rid, s_axi_bid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0] s_axi_awlen, s_axi_arlen;
  logic [2:0] s_axi_awsize, s_axi_arsize;
  logic [1:0] s_axi_awburst, s_axi_arburst, s_axi_rresp, s_axi_bresp;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rready;
  logic s_axi_bvalid, s_axi_bready;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_rid, m_axi_bid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_rresp, m_axi_bresp;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic m_axi_bvalid, m_axi_bready;
  logic rd_busy, wr_busy;

  int n_tests = 0;
  int n_fail  = 0;

  svc_axi_resp_delay #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .DELAY_WIDTH(DLW)
  ) dut (
    .clk(clk), .rst(rst), .rd_delay(rd_delay), .wr_delay(wr_delay),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awready(s_axi_awready),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arready(s_axi_arready),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rready(s_axi_rready),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bready(s_axi_bready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bready(m_axi_bready),
    .rd_busy(rd_busy), .wr_busy(wr_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, outputs are checked 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r(input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d,
                         input logic last);
    m_axi_rvalid = v;
    m_axi_rid    = id;
    m_axi_rdata  = d;
    m_axi_rresp  = 2'b00;
    m_axi_rlast  = last;
  endtask

  task automatic check_r(input string tag, input logic v, input logic [IW-1:0] id,
                         input logic [DW-1:0] d, input logic last);
    check_eq({tag, "_rvalid"}, 136'(s_axi_rvalid), 136'(v));
    if (v) begin
      check_eq({tag, "_rid"},   136'(s_axi_rid),   136'(id));
      check_eq({tag, "_rdata"}, 136'(s_axi_rdata), 136'(d));
      check_eq({tag, "_rlast"}, 136'(s_axi_rlast), 136'(last));
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_delay = '0; wr_delay = '0;
    s_axi_awvalid = 0; s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_arvalid = 0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_rready = 0; s_axi_bready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    drive_r(0, '0, '0, 0);
    m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = '0;

    // reset state, pass-through live during reset
    tick();
    s_axi_arvalid = 1; m_axi_arready = 1;
    #1;
    check_eq("rst_rvalid", 136'(s_axi_rvalid), 136'(0));
    check_eq("rst_bvalid", 136'(s_axi_bvalid), 136'(0));
    check_eq("rst_rd_busy", 136'(rd_busy), 136'(0));
    check_eq("rst_wr_busy", 136'(wr_busy), 136'(0));
    check_eq("rst_m_rready", 136'(m_axi_rready), 136'(1));
    check_eq("rst_m_bready", 136'(m_axi_bready), 136'(1));
    check_eq("rst_arvalid_pt", 136'(m_axi_arvalid), 136'(1));
    check_eq("rst_arready_pt", 136'(s_axi_arready), 136'(1));
    s_axi_arvalid = 0;
    @(posedge clk); #3 rst = 1'b0;

    // test 1: AR len=1, two R beats, delay 0
    tick();
    s_axi_arvalid = 1; s_axi_arid = 2'd1; s_axi_araddr = 12'h100; s_axi_arlen = 8'd1;
    s_axi_arsize = 3'd4; s_axi_arburst = 2'b01;
    #1;
    check_eq("t1_m_arvalid", 136'(m_axi_arvalid), 136'(1));
    check_eq("t1_m_araddr",  136'(m_axi_araddr),  136'(12'h100));
    check_eq("t1_m_arlen",   136'(m_axi_arlen),   136'(1));
    check_eq("t1_m_arid",    136'(m_axi_arid),    136'(1));
    tick();
    s_axi_arvalid = 0;
    rd_delay = 2'd0; s_axi_rready = 1;
    drive_r(1, 2'd1, 128'h1111, 0);
    #1;
    check_eq("t1_m_rready0", 136'(m_axi_rready), 136'(1));
    check_r("t1_pre", 0, '0, '0, 0);
    tick();
    drive_r(1, 2'd1, 128'h2222, 1);
    #1;
    check_r("t1_b0", 1, 2'd1, 128'h1111, 0);
    check_eq("t1_m_rready1", 136'(m_axi_rready), 136'(1));
    tick();
    drive_r(0, '0, '0, 0);
    #1;
    check_r("t1_b1", 1, 2'd1, 128'h2222, 1);
    tick();
    check_r("t1_done", 0, '0, '0, 0);
    check_eq("t1_busy", 136'(rd_busy), 136'(0));

    // test 2: rd_delay=3, single beat
    rd_delay = 2'd3;
    drive_r(1, 2'd2, 128'hA5, 1);
    tick();
    drive_r(0, '0, '0, 0);
    rd_delay = 2'd0;  // must not affect the held beat
    for (int i = 0; i < 3; i++) begin
      #1;
      check_r("t2_wait", 0, '0, '0, 0);
      check_eq("t2_m_rready", 136'(m_axi_rready), 136'(0));
      check_eq("t2_busy", 136'(rd_busy), 136'(1));
      tick();
    end
    check_r("t2_present", 1, 2'd2, 128'hA5, 1);
    tick();
    check_r("t2_done", 0, '0, '0, 0);

    // test 3: upstream stall for 5 cycles
    s_axi_rready = 0;
    drive_r(1, 2'd3, 128'hDEAD, 1);
    tick();
    drive_r(1, 2'd0, 128'hBEEF, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_r("t3_hold", 1, 2'd3, 128'hDEAD, 1);
      check_eq("t3_m_rready", 136'(m_axi_rready), 136'(0));
      tick();
    end
    s_axi_rready = 1;
    drive_r(0, '0, '0, 0);
    #1;
    check_r("t3_hs", 1, 2'd3, 128'hDEAD, 1);
    tick();
    check_r("t3_done", 0, '0, '0, 0);
    check_eq("t3_busy", 136'(rd_busy), 136'(0));

    // test 4: write path, wr_delay=2
    s_axi_awvalid = 1; s_axi_awid = 2'd2; s_axi_awaddr = 12'h040; s_axi_awlen = 8'd0;
    s_axi_wvalid = 1; s_axi_wdata = 128'hCAFE; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1;
    m_axi_awready = 1; m_axi_wready = 1;
    #1;
    check_eq("t4_m_awvalid", 136'(m_axi_awvalid), 136'(1));
    check_eq("t4_m_awaddr",  136'(m_axi_awaddr),  136'(12'h040));
    check_eq("t4_s_awready", 136'(s_axi_awready), 136'(1));
    check_eq("t4_m_wdata",   136'(m_axi_wdata),   136'(128'hCAFE));
    check_eq("t4_m_wlast",   136'(m_axi_wlast),   136'(1));
    check_eq("t4_s_wready",  136'(s_axi_wready),  136'(1));
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    wr_delay = 2'd2; s_axi_bready = 1;
    m_axi_bvalid = 1; m_axi_bid = 2'd2; m_axi_bresp = 2'b10;
    tick();
    m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = '0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("t4_bvalid_wait", 136'(s_axi_bvalid), 136'(0));
      check_eq("t4_m_bready", 136'(m_axi_bready), 136'(0));
      check_eq("t4_wr_busy", 136'(wr_busy), 136'(1));
      tick();
    end
    check_eq("t4_bvalid", 136'(s_axi_bvalid), 136'(1));
    check_eq("t4_bid",    136'(s_axi_bid),    136'(2));
    check_eq("t4_bresp",  136'(s_axi_bresp),  136'(2'b10));
    tick();
    check_eq("t4_done", 136'(s_axi_bvalid), 136'(0));
    wr_delay = 2'd0;

    // test 5: async reset mid-WAIT
    rd_delay = 2'd3;
    drive_r(1, 2'd1, 128'h77, 1);
    tick();
    drive_r(0, '0, '0, 0);
    tick();
    check_eq("t5_busy_pre", 136'(rd_busy), 136'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rvalid", 136'(s_axi_rvalid), 136'(0));
    check_eq("t5_busy", 136'(rd_busy), 136'(0));
    check_eq("t5_m_rready", 136'(m_axi_rready), 136'(1));
    @(posedge clk); #3 rst = 1'b0;
    tick();
    rd_delay = 2'd0;
    drive_r(1, 2'd2, 128'h99, 1);
    tick();
    drive_r(0, '0, '0, 0);
    #1;
    check_r("t5_after", 1, 2'd2, 128'h99, 1);
    tick();
    check_r("t5_done", 0, '0, '0, 0);

    // test 6: 4-beat stream with delay 0, then delay change
    drive_r(1, 2'd3, 128'h100, 0);
    #1;
    check_eq("t6_m_rready0", 136'(m_axi_rready), 136'(1));
    tick();
    for (int i = 1; i < 4; i++) begin
      drive_r(1, 2'd3, 128'(128'h100 + i), (i == 3));
      #1;
      check_r("t6_stream", 1, 2'd3, 128'(128'h100 + i - 1), 0);
      check_eq("t6_m_rready", 136'(m_axi_rready), 136'(1));
      tick();
    end
    drive_r(0, '0, '0, 0);
    rd_delay = 2'd2;
    #1;
    check_r("t6_last", 1, 2'd3, 128'h103, 1);
    tick();
    check_r("t6_gap", 0, '0, '0, 0);
    drive_r(1, 2'd0, 128'h200, 1);
    tick();
    drive_r(0, '0, '0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check_r("t6_wait", 0, '0, '0, 0);
      tick();
    end
    check_r("t6_late", 1, 2'd0, 128'h200, 1);
    tick();
    check_eq("t6_busy", 136'(rd_busy), 136'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
